// File: rtl/alu_share_arb_if.sv
// Request/response and shared-ALU signal bundle for alu_share_arb.
// slave = arbiter side, master = requesters plus the external ALU.
interface alu_share_arb_if #(
    parameter int unsigned GPR_BIT = 32,
    parameter int unsigned OPC_BIT = 6,
    parameter int unsigned TAG_BIT = 4
) ();
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [OPC_BIT-1:0] req0_op,    req1_op;
    logic [GPR_BIT-1:0] req0_rs,    req1_rs;
    logic [GPR_BIT-1:0] req0_rt,    req1_rt;
    logic [TAG_BIT-1:0] req0_tag,   req1_tag;

    logic [OPC_BIT-1:0] alu_op;
    logic [GPR_BIT-1:0] alu_rs, alu_rt;
    logic [GPR_BIT-1:0] alu_rd_value;

    logic               rsp0_valid, rsp1_valid;
    logic               rsp0_ready, rsp1_ready;
    logic [GPR_BIT-1:0] rsp0_data,  rsp1_data;
    logic [TAG_BIT-1:0] rsp0_tag,   rsp1_tag;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_rs, req1_rs,
               req0_rt, req1_rt, req0_tag, req1_tag,
               rsp0_ready, rsp1_ready, alu_rd_value,
        output req0_ready, req1_ready, alu_op, alu_rs, alu_rt,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_tag, rsp1_tag
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_rs, req1_rs,
               req0_rt, req1_rt, req0_tag, req1_tag,
               rsp0_ready, rsp1_ready, alu_rd_value,
        input  req0_ready, req1_ready, alu_op, alu_rs, alu_rt,
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_tag, rsp1_tag
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one combinational ALU between the EX stage (port 0)
// and the auxiliary/debug path (port 1), with single-entry response slots.
module alu_share_arb #(
    parameter int unsigned GPR_BIT = 32,
    parameter int unsigned OPC_BIT = 6,
    parameter int unsigned TAG_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_share_arb_if.slave    bus
);
    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state, state_nxt;
    logic               last_grant, owner;
    logic               elig0, elig1, grant_vld, grant, acc0, acc1;
    logic [OPC_BIT-1:0] op_q;
    logic [GPR_BIT-1:0] rs_q, rt_q;
    logic [TAG_BIT-1:0] tag_q;
    logic               rsp0_vld_q, rsp1_vld_q;
    logic [GPR_BIT-1:0] rsp0_data_q, rsp1_data_q;
    logic [TAG_BIT-1:0] rsp0_tag_q, rsp1_tag_q;

    // A port is eligible only once its slot is drained, so a pending result is never overwritten
    always_comb begin
        elig0          = bus.req0_valid && !rsp0_vld_q;
        elig1          = bus.req1_valid && !rsp1_vld_q;
        grant_vld      = elig0 || elig1;
        grant          = (elig0 && elig1) ? !last_grant : elig1;
        bus.req0_ready = (state == IDLE) && grant_vld && !grant && !flush;
        bus.req1_ready = (state == IDLE) && grant_vld && grant;
        acc0           = bus.req0_valid && bus.req0_ready;
        acc1           = bus.req1_valid && bus.req1_ready;
        state_nxt      = state;
        case (state)
            IDLE:    if (acc0 || acc1) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            tag_q       <= '0;
            rsp0_vld_q  <= 1'b0;
            rsp0_data_q <= '0;
            rsp0_tag_q  <= '0;
            rsp1_vld_q  <= 1'b0;
            rsp1_data_q <= '0;
            rsp1_tag_q  <= '0;
        end else begin
            if (acc0 || acc1) begin
                op_q       <= acc1 ? bus.req1_op  : bus.req0_op;
                rs_q       <= acc1 ? bus.req1_rs  : bus.req0_rs;
                rt_q       <= acc1 ? bus.req1_rt  : bus.req0_rt;
                tag_q      <= acc1 ? bus.req1_tag : bus.req0_tag;
                owner      <= acc1;
                last_grant <= acc1;
            end

            // Flush wins over both capture and drain: an in-flight port-0 result is dropped
            if (flush) begin
                rsp0_vld_q <= 1'b0;
            end else if (state == EXEC && !owner) begin
                rsp0_vld_q  <= 1'b1;
                rsp0_data_q <= bus.alu_rd_value;
                rsp0_tag_q  <= tag_q;
            end else if (rsp0_vld_q && bus.rsp0_ready) begin
                rsp0_vld_q <= 1'b0;
            end

            if (state == EXEC && owner) begin
                rsp1_vld_q  <= 1'b1;
                rsp1_data_q <= bus.alu_rd_value;
                rsp1_tag_q  <= tag_q;
            end else if (rsp1_vld_q && bus.rsp1_ready) begin
                rsp1_vld_q <= 1'b0;
            end
        end
    end

    assign bus.alu_op     = op_q;
    assign bus.alu_rs     = rs_q;
    assign bus.alu_rt     = rt_q;
    assign bus.rsp0_valid = rsp0_vld_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp0_tag   = rsp0_tag_q;
    assign bus.rsp1_valid = rsp1_vld_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.rsp1_tag   = rsp1_tag_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small combinational ALU stub.
module tb_alu_share_arb;
    localparam int unsigned GPR_BIT = 32;
    localparam int unsigned OPC_BIT = 6;
    localparam int unsigned TAG_BIT = 4;

    localparam logic [OPC_BIT-1:0] OP_ADD = 6'd0;
    localparam logic [OPC_BIT-1:0] OP_SUB = 6'd1;
    localparam logic [OPC_BIT-1:0] OP_AND = 6'd2;
    localparam logic [OPC_BIT-1:0] OP_XOR = 6'd3;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    alu_share_arb_if #(.GPR_BIT(GPR_BIT), .OPC_BIT(OPC_BIT), .TAG_BIT(TAG_BIT)) bus ();

    alu_share_arb #(.GPR_BIT(GPR_BIT), .OPC_BIT(OPC_BIT), .TAG_BIT(TAG_BIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            OP_ADD:  bus.alu_rd_value = bus.alu_rs + bus.alu_rt;
            OP_SUB:  bus.alu_rd_value = bus.alu_rs - bus.alu_rt;
            OP_AND:  bus.alu_rd_value = bus.alu_rs & bus.alu_rt;
            OP_XOR:  bus.alu_rd_value = bus.alu_rs ^ bus.alu_rt;
            default: bus.alu_rd_value = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [OPC_BIT-1:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] tag);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_rs = rs; bus.req0_rt = rt; bus.req0_tag = tag;
    endtask

    task automatic req1(input logic v, input logic [OPC_BIT-1:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] tag);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_rs = rs; bus.req1_rt = rt; bus.req1_tag = tag;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req0(1'b0, OP_ADD, 0, 0, 0);
        req1(1'b0, OP_ADD, 0, 0, 0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        step();
        step();
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_alu_rs", bus.alu_rs, 0);
        chk("rst_alu_rt", bus.alu_rt, 0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
        chk("rst_rsp0_data", bus.rsp0_data, 0);
        chk("rst_rsp1_tag", 32'(bus.rsp1_tag), 0);
        rst_n = 1'b1;
        step();

        // 1: single port-0 op
        req0(1'b1, OP_ADD, 5, 7, 3);
        #1;
        chk("t1_req0_ready", 32'(bus.req0_ready), 1);
        chk("t1_req1_ready", 32'(bus.req1_ready), 0);
        step();
        req0(1'b0, OP_ADD, 0, 0, 0);
        #1;
        chk("t1_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        chk("t1_alu_rs", bus.alu_rs, 5);
        chk("t1_alu_rt", bus.alu_rt, 7);
        chk("t1_exec_ready", 32'(bus.req0_ready), 0);
        step();
        chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 1);
        chk("t1_rsp0_data", bus.rsp0_data, 12);
        chk("t1_rsp0_tag", 32'(bus.rsp0_tag), 3);
        bus.rsp0_ready = 1'b1;
        step();
        chk("t1_rsp0_drain", 32'(bus.rsp0_valid), 0);
        bus.rsp0_ready = 1'b0;

        // 2: tie right after reset goes to port 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0(1'b1, OP_SUB, 10, 4, 1);
        req1(1'b1, OP_XOR, 32'hF0, 32'hFF, 2);
        #1;
        chk("t2_tie_ready0", 32'(bus.req0_ready), 1);
        chk("t2_tie_ready1", 32'(bus.req1_ready), 0);
        step();
        chk("t2_exec_ready1", 32'(bus.req1_ready), 0);
        step();
        chk("t2_rsp0_valid", 32'(bus.rsp0_valid), 1);
        chk("t2_rsp0_data", bus.rsp0_data, 6);
        chk("t2_ready0_blocked", 32'(bus.req0_ready), 0);
        chk("t2_ready1", 32'(bus.req1_ready), 1);
        step();
        req1(1'b0, OP_ADD, 0, 0, 0);
        step();
        chk("t2_rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("t2_rsp1_data", bus.rsp1_data, 32'h0F);
        chk("t2_rsp1_tag", 32'(bus.rsp1_tag), 2);
        chk("t2_rsp0_hold", bus.rsp0_data, 6);
        req0(1'b0, OP_ADD, 0, 0, 0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        chk("t2_drain0", 32'(bus.rsp0_valid), 0);
        chk("t2_drain1", 32'(bus.rsp1_valid), 0);

        // 3: round robin with both ports always valid (last grant was port 1)
        req0(1'b1, OP_ADD, 100, 1, 4);
        req1(1'b1, OP_ADD, 200, 2, 5);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3_ready0_c%0d", i), 32'(bus.req0_ready), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("t3_ready1_c%0d", i), 32'(bus.req1_ready), (i % 4 == 2) ? 1 : 0);
            step();
        end
        req0(1'b0, OP_ADD, 0, 0, 0);
        req1(1'b0, OP_ADD, 0, 0, 0);
        chk("t3_rsp1_data", bus.rsp1_data, 202);
        step();
        step();
        chk("t3_idle0", 32'(bus.rsp0_valid), 0);
        chk("t3_idle1", 32'(bus.rsp1_valid), 0);

        // 4: full port-1 slot blocks only port 1
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        req1(1'b1, OP_ADD, 32'hA0, 32'h0A, 5);
        #1;
        chk("t4_ready1", 32'(bus.req1_ready), 1);
        step();
        req1(1'b1, OP_SUB, 32'h55, 32'h11, 9);
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) req0(1'b1, OP_ADD, 1, 2, 6);
            if (i == 1) req0(1'b0, OP_ADD, 0, 0, 0);
            #1;
            if (i == 0) chk("t4_ready0", 32'(bus.req0_ready), 1);
            chk($sformatf("t4_ready1_c%0d", i), 32'(bus.req1_ready), 0);
            chk($sformatf("t4_rsp1_data_c%0d", i), bus.rsp1_data, 32'hAA);
            step();
        end
        chk("t4_rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("t4_rsp0_valid", 32'(bus.rsp0_valid), 1);
        chk("t4_rsp0_data", bus.rsp0_data, 3);
        chk("t4_rsp0_tag", 32'(bus.rsp0_tag), 6);
        req1(1'b0, OP_ADD, 0, 0, 0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        chk("t4_drain0", 32'(bus.rsp0_valid), 0);
        chk("t4_drain1", 32'(bus.rsp1_valid), 0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // 5: flush blocks port 0 and discards its in-flight result
        flush = 1'b1;
        req0(1'b1, OP_AND, 32'hFF, 32'h0F, 7);
        #1;
        chk("t5_flush_ready0", 32'(bus.req0_ready), 0);
        flush = 1'b0;
        #1;
        chk("t5_ready0", 32'(bus.req0_ready), 1);
        step();
        req0(1'b0, OP_ADD, 0, 0, 0);
        flush = 1'b1;
        #1;
        chk("t5_exec_op", 32'(bus.alu_op), 32'(OP_AND));
        step();
        flush = 1'b0;
        chk("t5_rsp0_dropped", 32'(bus.rsp0_valid), 0);
        req1(1'b1, OP_XOR, 3, 5, 8);
        #1;
        chk("t5_ready1", 32'(bus.req1_ready), 1);
        step();
        req1(1'b0, OP_ADD, 0, 0, 0);
        step();
        chk("t5_rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("t5_rsp1_data", bus.rsp1_data, 6);
        chk("t5_rsp0_still0", 32'(bus.rsp0_valid), 0);
        bus.rsp1_ready = 1'b1;
        step();
        bus.rsp1_ready = 1'b0;

        // 6: asynchronous reset during EXEC owned by port 0
        req0(1'b1, OP_ADD, 32'h11, 32'h22, 10);
        #1;
        chk("t6_ready0", 32'(bus.req0_ready), 1);
        step();
        req0(1'b0, OP_ADD, 0, 0, 0);
        chk("t6_exec_rs", bus.alu_rs, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("t6_async_rs", bus.alu_rs, 0);
        chk("t6_async_rt", bus.alu_rt, 0);
        chk("t6_async_op", 32'(bus.alu_op), 0);
        step();
        chk("t6_no_rsp0", 32'(bus.rsp0_valid), 0);
        chk("t6_rsp0_data", bus.rsp0_data, 0);
        rst_n = 1'b1;
        req0(1'b1, OP_ADD, 1, 1, 1);
        req1(1'b1, OP_ADD, 2, 2, 2);
        #1;
        chk("t6_tie_ready0", 32'(bus.req0_ready), 1);
        chk("t6_tie_ready1", 32'(bus.req1_ready), 0);
        step();
        req0(1'b0, OP_ADD, 0, 0, 0);
        req1(1'b0, OP_ADD, 0, 0, 0);
        step();
        chk("t6_rsp0_data_after", bus.rsp0_data, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Time-shares one combinational alu_ex instance between two requesters: port 0 is the pipeline EX stage, port 1 is the auxiliary/debug path.
- Registers the operands of the granted request, drives them into the shared ALU and captures rd_value into a per-requester response slot.
- Uses valid/ready on both the request side and the response side, with round-robin arbitration and a synchronous flush for port 0.

Parameters:
- GPR_BIT, 32, operand/result width.
- OPC_BIT, 6, ALU opcode width.
- TAG_BIT, 4, requester-supplied tag width, echoed on the response.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all port-0 work.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  OPC_BIT  ALU opcode.
- req0_rs / req1_rs  in  GPR_BIT  operand rs.
- req0_rt / req1_rt  in  GPR_BIT  operand rt (immediate already placed here).
- req0_tag / req1_tag  in  TAG_BIT  request tag.
- alu_op  out  OPC_BIT  to the shared ALU.
- alu_rs, alu_rt  out  GPR_BIT  to the shared ALU.
- alu_rd_value  in  GPR_BIT  from the shared ALU (combinational).
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  consumer takes result.
- rsp0_data / rsp1_data  out  GPR_BIT  result.
- rsp0_tag / rsp1_tag  out  TAG_BIT  echoed tag.

Behaviour:

Reset:
- rst_n low forces state=IDLE, last_grant=1 (port 0 wins the first tie) and all operand/response registers = 0.
- Consequently all outputs reset to 0: alu_op/alu_rs/alu_rt, rspX_valid/data/tag.
- Reset asserted mid-EXEC drops the in-flight operation; no response is produced.

FSM, two states:
- IDLE: arbitrate. Requester X is eligible when reqX_valid && !rspX_valid.
- IDLE, one requester eligible: it is granted.
- IDLE, both eligible: grant the one != last_grant.
- IDLE, no grant: stay IDLE.
- reqX_ready = (state==IDLE) && grant==X && !(X==0 && flush). At most one ready is high per cycle. ready may depend on valid.
- Handshake edge E0 (valid&&ready): load the op/rs/rt/tag registers, store owner=X, last_grant<=X, go to EXEC.
- EXEC: lasts exactly one cycle. alu_* outputs carry the registered operands.
- Edge E1: rspX_data<=alu_rd_value, rspX_tag<=tag reg, rspX_valid<=1, return to IDLE.
- Latency: response valid in the cycle after E1, i.e. 2 cycles after acceptance.
- Throughput: at most 1 op per 2 cycles.

ALU-side outputs:
- alu_op/alu_rs/alu_rt always drive the operand registers and are never combinationally forwarded from the req ports.
- Their values in IDLE are the last issued operands (don't-care to the ALU).

Response slots:
- Each slot is a single entry.
- rspX_valid clears on the edge where rspX_valid && rspX_ready.
- data/tag stay stable while valid && !ready.
- A slot must be drained before port X is eligible again, so a pending port-X result is never overwritten.
- A full slot on one port does not block the other port.

Flush:
- flush=1 forces req0_ready=0.
- It clears rsp0_valid on that edge.
- If state==EXEC with owner 0, the result is discarded: rsp0_valid stays 0 and the FSM still returns to IDLE.
- Port-1 work is unaffected by flush.
- flush together with rsp0_ready: the slot clears exactly once, with no other side effects.

Arithmetic: pure pass-through. Result width GPR_BIT, no truncation, no extension.

Test Plan:
1. Port-0 single op: req0 op=ADD rs=5 rt=7 tag=3 at cycle 0 -> req0_ready=1 at cycle 0, alu_rs=5/alu_rt=7 at cycle 1, rsp0_valid=1 data=12 tag=3 at cycle 2.
2. Simultaneous requests after reset: req0 SUB(10,4) and req1 XOR(0xF0,0xFF), both held -> port 0 granted first (rsp0 data=6), port 1 accepted 2 cycles later (rsp1 data=0x0F).
3. Round-robin fairness: both ports continuously valid, both rsp_ready=1 -> grants alternate 0,1,0,1 over 8 cycles; neither port is granted twice in a row.
4. Backpressure: rsp1_ready=0 with rsp1 holding 0xAA, req1 valid -> req1_ready stays 0 and rsp1_data stays 0xAA for 10 cycles; a port-0 op completes in the meantime.
5. Flush: accept req0 AND(0xFF,0x0F), assert flush in EXEC -> rsp0_valid never rises; next cycle a req1 op is accepted normally.
6. Reset mid-operation: drop rst_n during EXEC -> all outputs 0 immediately (asynchronously); after release the first tie grants port 0.
